// File: rtl/pds_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pds_resp_pkg
// Description : Shared types and constants for the PDS slave responder:
//               FSM state encoding, register-file depth and default
//               address-window match values.
// Revision    : 1.0 - initial release
// ============================================================================
package pds_resp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        WAIT   = 3'd2,
        ACK    = 3'd3,
        VPA    = 3'd4,
        BERR   = 3'd5,
        HOLD   = 3'd6
    } state_e;

    localparam int          REG_COUNT       = 8;
    localparam int          DEF_WAIT_STATES = 2;
    localparam logic [19:0] DEF_REG_BASE    = 20'hF0000;
    localparam logic [15:0] DEF_VPA_BASE    = 16'hEF00;

endpackage
`default_nettype wire

// File: rtl/pds_resp_if.sv
`default_nettype none
// ============================================================================
// Interface   : pds_resp_if
// Description : PDS bus bundle between a bus master and the pds_resp slave.
//               Master drives address, strobes and write data; the slave
//               returns read data and the active-low cycle terminations.
// Revision    : 1.0 - initial release
// ============================================================================
interface pds_resp_if;
    logic [23:1] A_IOB;
    logic        nAS_IOB;
    logic        nUDS_IOB;
    logic        nLDS_IOB;
    logic        nWE_IOB;
    logic        nVMA_IOB;
    logic        E;
    logic [15:0] D_IN;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        nDTACK_IOB;
    logic        nVPA_IOB;
    logic        nBERR_IOB;

    modport master (
        output A_IOB, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB, E, D_IN,
        input  D_OUT, D_OE, nDTACK_IOB, nVPA_IOB, nBERR_IOB
    );

    modport slave (
        input  A_IOB, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB, E, D_IN,
        output D_OUT, D_OE, nDTACK_IOB, nVPA_IOB, nBERR_IOB
    );
endinterface
`default_nettype wire

// File: rtl/pds_resp_sync.sv
`default_nettype none
// ============================================================================
// Module      : pds_resp_sync
// Description : Two-flop synchronizer for one asynchronous PDS input, with a
//               configurable value loaded on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pds_resp_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/pds_resp.sv
`default_nettype none
// ============================================================================
// Module      : pds_resp
// Description : PDS bus slave. Decodes an 8-word register window (nDTACK
//               after WAIT_STATES), a bus-error window next to it, and an
//               optional synchronous (nVPA/E-clocked) window with one byte
//               register. Unmatched cycles are held without termination.
// Config      : define PDS_RESP_VPA_EN to enable the VPA window and VREG;
//               when undefined that window decodes as an unterminated cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pds_resp
    import pds_resp_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter logic [19:0] REG_BASE    = DEF_REG_BASE,
    parameter logic [15:0] VPA_BASE    = DEF_VPA_BASE
) (
    input  wire logic C16M,
    input  wire logic RES,
    pds_resp_if.slave bus
);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    // Synchronized master strobes
    logic        as_s;
    logic        uds_s;
    logic        lds_s;

    // FSM and captured cycle attributes
    state_e      state_q, state_d;
    logic [23:1] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        w_reg_wr;

    // Register file and registered outputs
    logic [15:0] regs_q [REG_COUNT];
    logic [15:0] dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        dtack_n_q, dtack_n_d;
    logic        berr_n_q, berr_n_d;

    pds_resp_sync #(.RST_VAL(1'b1)) u_sync_as  (.clk(C16M), .rst(RES), .d_i(bus.nAS_IOB),  .q_o(as_s));
    pds_resp_sync #(.RST_VAL(1'b1)) u_sync_uds (.clk(C16M), .rst(RES), .d_i(bus.nUDS_IOB), .q_o(uds_s));
    pds_resp_sync #(.RST_VAL(1'b1)) u_sync_lds (.clk(C16M), .rst(RES), .d_i(bus.nLDS_IOB), .q_o(lds_s));

    // Next-state logic: address/direction latched on cycle start, decode, wait count
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_n_d  = we_n_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!as_s) begin
                    state_d = DECODE;
                    addr_d  = bus.A_IOB;
                    we_n_d  = bus.nWE_IOB;
                end
            end
            DECODE: begin
                if (as_s) begin
                    state_d = IDLE;
                end else if (addr_q[23:4] == REG_BASE) begin
                    state_d = WAIT;
                    cnt_d   = WS_LOAD;
                end else if ((addr_q[23:8] == REG_BASE[19:4]) && (addr_q[7:4] != 4'h0)) begin
                    state_d = BERR;
                end else if (addr_q[23:8] == VPA_BASE) begin
`ifdef PDS_RESP_VPA_EN
                    state_d = VPA;
`else
                    state_d = HOLD;
`endif
                end else begin
                    state_d = HOLD;
                end
            end
            WAIT: begin
                // A write may only complete once the master shows a byte lane
                if (as_s) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    if (we_n_q || !uds_s || !lds_s) begin
                        state_d = ACK;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK, VPA, BERR, HOLD: begin
                if (as_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register writes happen exactly once, on the edge that enters ACK
    assign w_reg_wr = (state_q == WAIT) && (state_d == ACK) && !we_n_q;

`ifdef PDS_RESP_VPA_EN
    logic       vma_s;
    logic       e_s;
    logic       e_prev_q;
    logic       vpa_done_q, vpa_done_d;
    logic       vpa_n_q, vpa_n_d;
    logic [7:0] vreg_q;
    logic       w_e_fall;
    logic       w_vpa_xfer;

    pds_resp_sync #(.RST_VAL(1'b1)) u_sync_vma (.clk(C16M), .rst(RES), .d_i(bus.nVMA_IOB), .q_o(vma_s));
    pds_resp_sync #(.RST_VAL(1'b0)) u_sync_e   (.clk(C16M), .rst(RES), .d_i(bus.E),        .q_o(e_s));

    // Only the first qualified E falling edge of a VPA cycle transfers
    assign w_e_fall   = e_prev_q & ~e_s;
    assign w_vpa_xfer = (state_q == VPA) && !vpa_done_q && w_e_fall && !vma_s;
    assign vpa_done_d = (state_q == VPA) && (vpa_done_q || w_vpa_xfer);
    assign vpa_n_d    = (state_d != VPA);

    // E edge history, single-transfer flag, VREG and nVPA output
    always_ff @(posedge C16M) begin
        if (RES) begin
            e_prev_q   <= 1'b0;
            vpa_done_q <= 1'b0;
            vreg_q     <= 8'h00;
            vpa_n_q    <= 1'b1;
        end else begin
            e_prev_q   <= e_s;
            vpa_done_q <= vpa_done_d;
            vpa_n_q    <= vpa_n_d;
            if (w_vpa_xfer && !we_n_q && !lds_s) begin
                vreg_q <= bus.D_IN[7:0];
            end
        end
    end

    assign bus.nVPA_IOB = vpa_n_q;
`else
    logic unused_vpa_in;
    assign unused_vpa_in = bus.E ^ bus.nVMA_IOB;
    assign bus.nVPA_IOB  = 1'b1;
`endif

    // Output next values follow the next state so terminations change on the same edge
    always_comb begin
        dtack_n_d = (state_d != ACK);
        berr_n_d  = (state_d != BERR);
        doe_d     = 1'b0;
        dout_d    = 16'h0000;
        if ((state_d == ACK) && we_n_q) begin
            doe_d  = 1'b1;
            dout_d = regs_q[addr_q[3:1]];
        end
`ifdef PDS_RESP_VPA_EN
        else if ((state_d == VPA) && we_n_q) begin
            doe_d  = 1'b1;
            dout_d = {8'h00, vreg_q};
        end
`endif
    end

    // State, cycle attributes, register file and output registers
    always_ff @(posedge C16M) begin
        if (RES) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_n_q    <= 1'b1;
            cnt_q     <= 3'd0;
            dout_q    <= 16'h0000;
            doe_q     <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_n_q    <= we_n_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            if (w_reg_wr) begin
                if (!uds_s) begin
                    regs_q[addr_q[3:1]][15:8] <= bus.D_IN[15:8];
                end
                if (!lds_s) begin
                    regs_q[addr_q[3:1]][7:0] <= bus.D_IN[7:0];
                end
            end
        end
    end

    assign bus.D_OUT      = dout_q;
    assign bus.D_OE       = doe_q;
    assign bus.nDTACK_IOB = dtack_n_q;
    assign bus.nBERR_IOB  = berr_n_q;

endmodule
`default_nettype wire

// File: doc/pds_resp.md
PDS_RESP -- requirements
Module: pds_resp

Interface
REQ-001 SHALL provide parameter WAIT_STATES, default 2, C16M cycles inserted between decode and nDTACK assertion (0..7).
REQ-002 SHALL provide parameter REG_BASE, default 20'hF0000, A[23:4] match value for the register window 0xF00000-0xF0000F.
REQ-003 SHALL provide parameter VPA_BASE, default 16'hEF00, A[23:8] match value for the synchronous window 0xEF0000-0xEF00FF.
REQ-004 SHALL have one clock, C16M, input 1, sampling all PDS inputs on its rising edge.
REQ-005 SHALL have reset RES, input 1, synchronous, active-high.
REQ-006 SHALL have A_IOB input 23 (A[23:1]), nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB and E, each input 1, asynchronous PDS master signals.
REQ-007 SHALL have D_IN input 16 (write data), D_OUT output 16 (read data) and D_OE output 1 (read-data drive enable).
REQ-008 SHALL have nDTACK_IOB, nVPA_IOB and nBERR_IOB, each output 1, active-low cycle terminations.

Function
REQ-009 SHALL pass nAS_IOB, nUDS_IOB, nLDS_IOB, nVMA_IOB and E through 2-flop synchronizers; all decisions use synchronized copies.
REQ-010 SHALL use states IDLE, DECODE, WAIT, ACK, VPA, BERR, HOLD.
REQ-011 IDLE->DECODE on first cycle synchronized nAS low; A_IOB and nWE_IOB captured there.
REQ-012 DECODE (1 cycle): A[23:4]==REG_BASE -> WAIT (count loaded WAIT_STATES); A[23:8]==REG_BASE[19:4] with A[7:4]!=0 -> BERR; A[23:8]==VPA_BASE -> VPA; else -> HOLD with no termination asserted.
REQ-013 WAIT leaves for ACK when count is 0 and, for writes, at least one synchronized strobe is low; otherwise stays.
REQ-014 ACK: nDTACK low; reads drive D_OUT = REG[A[3:1]] with D_OE high; writes update REG[A[3:1]] once on ACK entry, upper byte only if nUDS low, lower byte only if nLDS low.
REQ-015 BERR: nBERR low, no register change, D_OE low.
REQ-016 VPA: nVPA low; read data VREG on D_OUT[7:0], D_OUT[15:8]=0, D_OE high from entry; transfer occurs on first synchronized E falling edge with synchronized nVMA low; writes capture D_IN[7:0] into VREG at that edge only if nLDS low.
REQ-017 ACK, BERR, VPA, HOLD SHALL hold outputs until synchronized nAS high, then go to IDLE, releasing all terminations and D_OE on that same edge.
REQ-018 nAS rising during WAIT or DECODE SHALL abort to IDLE with no termination and no write.
REQ-019 Latency with WAIT_STATES=N: nDTACK low exactly N+4 C16M edges after the edge at which raw nAS is first sampled low (2 sync, 1 IDLE detect, 1 DECODE).
REQ-020 Only one termination output SHALL ever be low at a time.

Reset
REQ-021 RES high SHALL force state IDLE, nDTACK/nVPA/nBERR high, D_OE 0, D_OUT 0, REG[0..7] and VREG to 0, synchronizers to 1 (E stage to 0), on the next edge, including mid-cycle.

Configuration
REQ-022 Macro PDS_RESP_VPA_EN defined: VPA window and VREG present per REQ-016.
REQ-023 PDS_RESP_VPA_EN undefined: VPA_BASE matches decode to HOLD, nVPA_IOB tied high, VREG and E/nVMA synchronizers removed.

Structure
REQ-024 Package pds_resp_pkg SHALL hold the state enum, REG_COUNT=8, default window constants.
REQ-025 Sub-module pds_resp_sync (2-flop synchronizer, parameterized reset value) SHALL be instantiated per asynchronous input.

Verification
REQ-026 Write 0xBEEF to 0xF00006, UDS+LDS, WAIT_STATES=2 -> nDTACK low 6 edges after nAS; readback of 0xF00006 returns 0xBEEF.
REQ-027 Byte write 0x12 to 0xF00007 (LDS only) over 0xBEEF -> readback 0xBE12.
REQ-028 Read 0xF00020 -> nBERR low, nDTACK/nVPA high, D_OE 0 until nAS rises.
REQ-029 Write 0x5A to 0xEF0001, nVMA low, E falls 5 cycles later -> VREG=0x5A only after E fall; nVPA released on nAS rise; without PDS_RESP_VPA_EN, no termination asserted.
REQ-030 RES pulse during ACK of write -> all outputs released next edge, REG all 0.
REQ-031 nAS deasserted during WAIT (WAIT_STATES=7) -> no nDTACK, register unchanged, back to IDLE.
